nested_gather: RTL

//   Fan-in counterpart of the nested broadcast: collects the two leaf copies
//   (leaf a = true polarity, leaf b = inverted polarity) of one value.
//   Re-aligns the leaves into pairs and returns a single checked stream to the

---
 rtl/nested_gather_pkg.sv | 17 +
 rtl/nested_gather_slot.sv | 34 +++
 rtl/nested_gather.sv | 119 +++++++++++
 3 files changed

// File: rtl/nested_gather_pkg.sv
// Shared types for nested_gather: the pairing state derived from the two slot
// full flags (bit 0 = slot a full, bit 1 = slot b full).
package nested_gather_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        HAVE_A = 2'b01,
        HAVE_B = 2'b10,
        BOTH   = 2'b11
    } pair_state_t;

    // Pack the two slot flags into the pairing state.
    function automatic pair_state_t pair_state(input logic full_a, input logic full_b);
        return pair_state_t'({full_b, full_a});
    endfunction

endpackage

// File: rtl/nested_gather_slot.sv
// gather_slot: one-entry hold register with a full flag.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture din (optionally inverted) and set full
//   clear     : drop the held word (load wins when both are high)
//   din       : incoming leaf word
//   full      : a word is held
//   dout      : held word
module gather_slot #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    // Hold register; a load in the same cycle as a clear refills the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= INVERT ? ~din : din;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/nested_gather.sv
// nested_gather: re-pairs the two leaf copies of one value (a = true polarity,
// b = inverted polarity) and emits one checked stream with running counters.
//   clk, rst              : clock, asynchronous active-high reset
//   a_valid/a_ready/a_data: leaf a handshake
//   b_valid/b_ready/b_data: leaf b handshake
//   out_valid/out_ready   : result handshake
//   out_data              : slot a value of the emitted pair
//   out_mismatch          : pair failed the complement check
//   pair_count            : pairs emitted, wrapping
//   mismatch_count        : mismatching pairs, saturating
module nested_gather
    import nested_gather_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          INVERT_B = 1'b1,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [WIDTH-1:0]   a_data,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [WIDTH-1:0]   b_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_mismatch,
    output logic [COUNT_W-1:0] pair_count,
    output logic [COUNT_W-1:0] mismatch_count
);

    logic             full_a;
    logic             full_b;
    logic [WIDTH-1:0] slot_a;
    logic [WIDTH-1:0] slot_b;
    logic             load_a;
    logic             load_b;
    logic             fire;
    pair_state_t      state;

    logic               out_valid_d;
    logic [WIDTH-1:0]   out_data_d;
    logic               out_mismatch_d;
    logic [COUNT_W-1:0] pair_count_d;
    logic [COUNT_W-1:0] mismatch_count_d;

    // Pairing state is just the two slot flags; fire empties both slots.
    assign state   = pair_state(full_a, full_b);
    assign fire    = (state == BOTH) && (!out_valid || out_ready);
    assign a_ready = !full_a || fire;
    assign b_ready = !full_b || fire;
    assign load_a  = a_valid && a_ready;
    assign load_b  = b_valid && b_ready;

    if (1) begin : a
        gather_slot #(.WIDTH(WIDTH), .INVERT(1'b0)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_a),
            .clear (fire),
            .din   (a_data),
            .full  (full_a),
            .dout  (slot_a)
        );
    end

    // Slot b stores the un-inverted value so the compare is a plain equality.
    if (1) begin : b
        gather_slot #(.WIDTH(WIDTH), .INVERT(INVERT_B)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load_b),
            .clear (fire),
            .din   (b_data),
            .full  (full_b),
            .dout  (slot_b)
        );
    end

    // Next values for the output register and counters.
    always_comb begin
        out_valid_d      = out_valid;
        out_data_d       = out_data;
        out_mismatch_d   = out_mismatch;
        pair_count_d     = pair_count;
        mismatch_count_d = mismatch_count;
        if (fire) begin
            out_valid_d    = 1'b1;
            out_data_d     = slot_a;
            out_mismatch_d = (slot_a != slot_b);
            pair_count_d   = pair_count + COUNT_W'(1);
            if (out_mismatch_d && (mismatch_count != {COUNT_W{1'b1}})) begin
                mismatch_count_d = mismatch_count + COUNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_mismatch   <= 1'b0;
            pair_count     <= '0;
            mismatch_count <= '0;
        end else begin
            out_valid      <= out_valid_d;
            out_data       <= out_data_d;
            out_mismatch   <= out_mismatch_d;
            pair_count     <= pair_count_d;
            mismatch_count <= mismatch_count_d;
        end
    end

endmodule
